// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the IFU, LSU and memory-side handshake signals of the
//               memory arbiter. The master modport is the arbiter's view
//               (it masters the memory port and answers both requesters);
//               the slave modport is the surrounding requesters and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
);
    localparam int MASK_LEN = DATA_LEN / 8;

    // Instruction-fetch requester
    logic                ifu_req_valid;
    logic [ADDR_LEN-1:0] ifu_addr;
    logic                ifu_req_ready;
    logic                ifu_resp_valid;
    logic [DATA_LEN-1:0] ifu_rdata;

    // Load/store requester
    logic                lsu_req_valid;
    logic [ADDR_LEN-1:0] lsu_addr;
    logic                lsu_wen;
    logic [DATA_LEN-1:0] lsu_wdata;
    logic [MASK_LEN-1:0] lsu_wmask;
    logic                lsu_req_ready;
    logic                lsu_resp_valid;
    logic [DATA_LEN-1:0] lsu_rdata;

    // Memory / bus slave port
    logic                mem_req_valid;
    logic [ADDR_LEN-1:0] mem_addr;
    logic                mem_wen;
    logic [DATA_LEN-1:0] mem_wdata;
    logic [MASK_LEN-1:0] mem_wmask;
    logic                mem_req_ready;
    logic                mem_resp_valid;
    logic [DATA_LEN-1:0] mem_rdata;

    // Current owner of the memory port (0 = IFU, 1 = LSU)
    logic                owner;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output owner
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  owner
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one external memory port between the instruction
//               fetch unit and the load/store unit. One transaction is in
//               flight at a time: accept (IDLE), issue (REQ), wait for the
//               response and route it to the owner (RESP).
//               Optional macro MEM_ARBITER_RR_EN: round-robin on ties using a
//               last_owner register; without it the LSU always wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  wire           sys_clk,
    input  wire           sys_rst,
    mem_arbiter_if.master bus
);
    localparam int MASK_LEN = DATA_LEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q,         state_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_LEN-1:0] mem_addr_q,      mem_addr_d;
    logic                mem_wen_q,       mem_wen_d;
    logic [DATA_LEN-1:0] mem_wdata_q,     mem_wdata_d;
    logic [MASK_LEN-1:0] mem_wmask_q,     mem_wmask_d;
    logic                owner_q,         owner_d;
`ifdef MEM_ARBITER_RR_EN
    logic                last_owner_q,    last_owner_d;
`endif

    logic grant_lsu;
    logic grant_ifu;
    logic resp_fire;

    // Pick a winner among the pending requesters (only meaningful in IDLE)
    always_comb begin
        grant_lsu = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        // On a tie the LSU wins only if the IFU was served last
        grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_owner_q);
`else
        grant_lsu = bus.lsu_req_valid;
`endif
        grant_ifu = bus.ifu_req_valid & ~grant_lsu;
    end

    // Next-state and payload-latch logic of the transaction FSM
    always_comb begin
        state_d         = state_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        mem_wen_d       = mem_wen_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        owner_d         = owner_q;
`ifdef MEM_ARBITER_RR_EN
        last_owner_d    = last_owner_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_lsu) begin
                    mem_addr_d      = bus.lsu_addr;
                    mem_wen_d       = bus.lsu_wen;
                    mem_wdata_d     = bus.lsu_wdata;
                    mem_wmask_d     = bus.lsu_wmask;
                    owner_d         = 1'b1;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_REQ;
                end else if (grant_ifu) begin
                    // Fetches are always reads with no write payload
                    mem_addr_d      = bus.ifu_addr;
                    mem_wen_d       = 1'b0;
                    mem_wdata_d     = '0;
                    mem_wmask_d     = '0;
                    owner_d         = 1'b0;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_REQ;
                end
`ifdef MEM_ARBITER_RR_EN
                if (grant_lsu | grant_ifu) begin
                    last_owner_d = grant_lsu;
                end
`endif
            end
            ST_REQ: begin
                // Payload stays frozen until the slave takes it
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.mem_resp_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                mem_req_valid_d = 1'b0;
                state_d         = ST_IDLE;
            end
        endcase
    end

    // State and latched-payload registers with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q         <= ST_IDLE;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            owner_q         <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_owner_q    <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_wen_q       <= mem_wen_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
            owner_q         <= owner_d;
`ifdef MEM_ARBITER_RR_EN
            last_owner_q    <= last_owner_d;
`endif
        end
    end

    // Ready only in IDLE; responses routed to the owner only in RESP
    always_comb begin
        resp_fire          = (state_q == ST_RESP) & bus.mem_resp_valid;
        bus.ifu_req_ready  = (state_q == ST_IDLE) & grant_ifu;
        bus.lsu_req_ready  = (state_q == ST_IDLE) & grant_lsu;
        bus.ifu_resp_valid = resp_fire & ~owner_q;
        bus.lsu_resp_valid = resp_fire &  owner_q;
        bus.ifu_rdata      = (resp_fire & ~owner_q) ? bus.mem_rdata : '0;
        bus.lsu_rdata      = (resp_fire &  owner_q) ? bus.mem_rdata : '0;
        bus.mem_req_valid  = mem_req_valid_q;
        bus.mem_addr       = mem_addr_q;
        bus.mem_wen        = mem_wen_q;
        bus.mem_wdata      = mem_wdata_q;
        bus.mem_wmask      = mem_wmask_q;
        bus.owner          = owner_q;
    end

endmodule
`default_nettype wire
